// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
// Round-robin arbiter/sequencer for the shared 32-bit write-back path.
// Drives the 8-input selector's select and captures its output into a
// registered valid/ready slot. A one-cycle acknowledge goes to the requester
// whose word was taken. A grant is held for up to BURST consecutive words.

module wb_port_arbiter #(
    parameter int unsigned BURST = 4  // max consecutive transfers per grant, 1..8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  req,
    input  logic [31:0] mux_r,
    input  logic        wb_ready,
    output logic [2:0]  sel,
    output logic [2:0]  owner,
    output logic [7:0]  ack,
    output logic        wb_valid,
    output logic [31:0] wb_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        NEXT = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [2:0]  ptr, ptr_n;
    logic [2:0]  cnt, cnt_n;
    logic [2:0]  sel_n;
    logic [7:0]  ack_n;
    logic        valid_n;
    logic [31:0] data_n;

    // {found, index} of the first set request at or after base, wrapping 7->0
    logic [3:0]  win_idle;
    logic [3:0]  win_next;
    logic        burst_more;

    function automatic logic [3:0] find_winner(input logic [7:0] r, input logic [2:0] base);
        logic [3:0] res;
        logic [2:0] idx;
        res = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = base + 3'(i);
            if (!res[3] && r[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign win_idle = find_winner(req, ptr);
    // Searching from sel+1 makes the releasing requester the last candidate,
    // so it only wins again when nobody else is asking.
    assign win_next = find_winner(req, sel + 3'd1);
    // Widened compare keeps BURST=1 free of an always-false constant test.
    assign burst_more = ({1'b0, cnt} + 4'd1) < 4'(BURST);

    assign owner = sel;

    // State, select, pointer, burst count and output slot registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= '0;
            ptr      <= '0;
            cnt      <= '0;
            ack      <= '0;
            wb_valid <= 1'b0;
            wb_data  <= '0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            ptr      <= ptr_n;
            cnt      <= cnt_n;
            ack      <= ack_n;
            wb_valid <= valid_n;
            wb_data  <= data_n;
        end
    end

    // Next-state, grant selection, capture and slot flow control
    always_comb begin
        state_n = state;
        sel_n   = sel;
        ptr_n   = ptr;
        cnt_n   = cnt;
        ack_n   = '0;
        valid_n = wb_valid;
        data_n  = wb_data;

        // Consumer drains the slot; a capture below overrides this.
        if (wb_valid && wb_ready) begin
            valid_n = 1'b0;
        end

        case (state)
            IDLE: begin
                if (win_idle[3]) begin
                    sel_n   = win_idle[2:0];
                    cnt_n   = '0;
                    state_n = XFER;
                end
            end
            XFER: begin
                if (!wb_valid || wb_ready) begin
                    data_n  = mux_r;
                    valid_n = 1'b1;
                    ack_n   = 8'd1 << sel;
                    state_n = NEXT;
                end
            end
            NEXT: begin
                if (req[sel] && burst_more) begin
                    cnt_n   = cnt + 3'd1;
                    state_n = XFER;
                end else begin
                    ptr_n = sel + 3'd1;
                    if (win_next[3]) begin
                        sel_n   = win_next[2:0];
                        cnt_n   = '0;
                        state_n = XFER;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed testbench for wb_port_arbiter: one instance with BURST=4 and a
// second with BURST=1 for the fair-rotation scenario.

module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [31:0] mux_r;
    logic        wb_ready;
    logic [2:0]  sel;
    logic [2:0]  owner;
    logic [7:0]  ack;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [31:0] salt;

    logic [7:0]  req1;
    logic [31:0] mux_r1;
    logic        ready1;
    logic [2:0]  sel1;
    logic [2:0]  owner1;
    logic [7:0]  ack1;
    logic        valid1;
    logic [31:0] data1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Selector model: each nibble carries the select value (sel=3 -> 0x33333333)
    assign mux_r  = {8{1'b0, sel}} ^ salt;
    assign mux_r1 = {8{1'b0, sel1}};

    wb_port_arbiter #(.BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .mux_r(mux_r), .wb_ready(wb_ready),
        .sel(sel), .owner(owner), .ack(ack), .wb_valid(wb_valid), .wb_data(wb_data)
    );

    wb_port_arbiter #(.BURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .mux_r(mux_r1), .wb_ready(ready1),
        .sel(sel1), .owner(owner1), .ack(ack1), .wb_valid(valid1), .wb_data(data1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req = '0; req1 = '0; wb_ready = 1'b1; ready1 = 1'b1; salt = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL reset_sel: got %0d expected 0", sel); end
        checks++; if (owner !== 3'd0) begin errors++; $display("FAIL reset_owner: got %0d expected 0", owner); end
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL reset_ack: got %h expected 00", ack); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", wb_data); end
    endtask

    task automatic test_single;
        req = 8'h08;
        tick();
        checks++; if (sel !== 3'd3) begin errors++; $display("FAIL single_sel: got %0d expected 3", sel); end
        checks++; if (owner !== 3'd3) begin errors++; $display("FAIL single_owner: got %0d expected 3", owner); end
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL single_early_ack: got %h expected 00", ack); end
        tick();
        checks++; if (ack !== 8'h08) begin errors++; $display("FAIL single_ack: got %h expected 08", ack); end
        checks++; if (wb_data !== 32'h33333333) begin errors++; $display("FAIL single_data: got %h expected 33333333", wb_data); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b expected 1", wb_valid); end
        req = 8'h00;
        tick();
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL single_ack_drop: got %h expected 00", ack); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_consumed: got %b expected 0", wb_valid); end
        tick();
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL single_idle_ack: got %h expected 00", ack); end
        checks++; if (sel !== 3'd3) begin errors++; $display("FAIL single_idle_sel: got %0d expected 3", sel); end
    endtask

    task automatic test_reset_mid;
        req = 8'h08;
        tick();
        tick();
        checks++; if (ack !== 8'h08) begin errors++; $display("FAIL rmid_pre_ack: got %h expected 08", ack); end
        rst = 1'b1;
        #1;
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL rmid_ack: got %h expected 00", ack); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %b expected 0", wb_valid); end
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL rmid_sel: got %0d expected 0", sel); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rmid_data: got %h expected 0", wb_data); end
        req = 8'h00;
        #2;
        rst = 1'b0;
        tick();
        req = 8'h20;
        tick();
        checks++; if (sel !== 3'd5) begin errors++; $display("FAIL rmid_idle_sel: got %0d expected 5", sel); end
        tick();
        checks++; if (ack !== 8'h20) begin errors++; $display("FAIL rmid_idle_ack: got %h expected 20", ack); end
        req = 8'h00;
        tick();
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL rmid_ack_end: got %h expected 00", ack); end
    endtask

    task automatic test_backpressure;
        wb_ready = 1'b1;
        req = 8'h08;
        tick();
        checks++; if (sel !== 3'd3) begin errors++; $display("FAIL bp_sel: got %0d expected 3", sel); end
        tick();
        checks++; if (ack !== 8'h08) begin errors++; $display("FAIL bp_first_ack: got %h expected 08", ack); end
        wb_ready = 1'b0;
        tick();
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL bp_next_ack: got %h expected 00", ack); end
        salt = 32'hFFFF0000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (ack !== 8'h00) begin errors++; $display("FAIL bp_stall_ack[%0d]: got %h expected 00", i, ack); end
            checks++; if (wb_data !== 32'h33333333) begin errors++; $display("FAIL bp_stall_data[%0d]: got %h expected 33333333", i, wb_data); end
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d]: got %b expected 1", i, wb_valid); end
            checks++; if (sel !== 3'd3) begin errors++; $display("FAIL bp_stall_sel[%0d]: got %0d expected 3", i, sel); end
        end
        wb_ready = 1'b1;
        tick();
        checks++; if (ack !== 8'h08) begin errors++; $display("FAIL bp_release_ack: got %h expected 08", ack); end
        checks++; if (wb_data !== 32'hCCCC3333) begin errors++; $display("FAIL bp_release_data: got %h expected cccc3333", wb_data); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL bp_release_valid: got %b expected 1", wb_valid); end
        req = 8'h00;
        tick();
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL bp_end_ack: got %h expected 00", ack); end
        salt = '0;
    endtask

    task automatic test_burst;
        int          exp_owner [12] = '{5, 5, 5, 5, 2, 2, 2, 2, 5, 5, 5, 5};
        logic [2:0]  e;
        logic [31:0] exp_data;
        req = 8'h24;
        tick();
        checks++; if (sel !== 3'd5) begin errors++; $display("FAIL burst_first_sel: got %0d expected 5", sel); end
        for (int n = 0; n < 12; n++) begin
            e = 3'(exp_owner[n]);
            exp_data = {8{1'b0, e}};
            tick();
            checks++; if (ack !== (8'd1 << e)) begin errors++; $display("FAIL burst_ack[%0d]: got %h expected %h", n, ack, 8'd1 << e); end
            checks++; if (wb_data !== exp_data) begin errors++; $display("FAIL burst_data[%0d]: got %h expected %h", n, wb_data, exp_data); end
            if (n == 11) req = 8'h00;
            tick();
            checks++; if (ack !== 8'h00) begin errors++; $display("FAIL burst_gap[%0d]: got %h expected 00", n, ack); end
        end
    endtask

    task automatic test_wrap;
        req = 8'h80;
        tick();
        checks++; if (sel !== 3'd7) begin errors++; $display("FAIL wrap_sel7: got %0d expected 7", sel); end
        tick();
        checks++; if (ack !== 8'h80) begin errors++; $display("FAIL wrap_ack7: got %h expected 80", ack); end
        req = 8'h41;
        tick();
        checks++; if (sel !== 3'd0) begin errors++; $display("FAIL wrap_sel0: got %0d expected 0", sel); end
        checks++; if (dut.ptr !== 3'd0) begin errors++; $display("FAIL wrap_ptr: got %0d expected 0", dut.ptr); end
        tick();
        checks++; if (ack !== 8'h01) begin errors++; $display("FAIL wrap_ack0: got %h expected 01", ack); end
        req = 8'h40;
        tick();
        checks++; if (sel !== 3'd6) begin errors++; $display("FAIL wrap_sel6: got %0d expected 6", sel); end
        tick();
        checks++; if (ack !== 8'h40) begin errors++; $display("FAIL wrap_ack6: got %h expected 40", ack); end
        req = 8'h00;
        tick();
        checks++; if (ack !== 8'h00) begin errors++; $display("FAIL wrap_end_ack: got %h expected 00", ack); end
    endtask

    task automatic test_rotation;
        logic [2:0] e;
        req1 = 8'hFF;
        tick();
        checks++; if (sel1 !== 3'd0) begin errors++; $display("FAIL rot_first_sel: got %0d expected 0", sel1); end
        for (int n = 0; n < 9; n++) begin
            e = 3'(n % 8);
            tick();
            checks++; if (ack1 !== (8'd1 << e)) begin errors++; $display("FAIL rot_ack[%0d]: got %h expected %h", n, ack1, 8'd1 << e); end
            checks++; if (owner1 !== e) begin errors++; $display("FAIL rot_owner[%0d]: got %0d expected %0d", n, owner1, e); end
            if (n == 8) req1 = 8'h00;
            tick();
            checks++; if (ack1 !== 8'h00) begin errors++; $display("FAIL rot_gap[%0d]: got %h expected 00", n, ack1); end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_reset_mid();
        test_backpressure();
        test_burst();
        test_wrap();
        test_rotation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
